fc_dense: RTL



---
 rtl/fc_dense.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fc_dense.sv
// Fully connected classifier: flattens pooled maps and runs one MAC per element against a synchronous weight ROM.
// Define FC_ARGMAX_EN to build the running-maximum class index; otherwise class_idx is tied to 0.
module fc_dense #(
    parameter int IN_CH     = 32,
    parameter int IN_DIM    = 7,
    parameter int NUM_OUT   = 10,
    parameter int W_WIDTH   = 16,
    parameter int FRAC_BITS = 8,
    parameter int W_ADDR_W  = 14
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic                         done,
    input  logic signed [31:0]           pooled_maps [0:IN_CH-1][0:IN_DIM-1][0:IN_DIM-1],
    input  logic signed [31:0]           biases [0:NUM_OUT-1],
    output logic [W_ADDR_W-1:0]          w_addr,
    input  logic signed [W_WIDTH-1:0]    w_data,
    output logic signed [31:0]           scores [0:NUM_OUT-1],
    output logic [$clog2(NUM_OUT)-1:0]   class_idx
);

    localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int DW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int OW = $clog2(NUM_OUT);
    localparam int PW = W_WIDTH + 32;

    localparam logic [CW-1:0] F_LAST = CW'(IN_CH - 1);
    localparam logic [DW-1:0] D_LAST = DW'(IN_DIM - 1);
    localparam logic [OW-1:0] O_LAST = OW'(NUM_OUT - 1);

    localparam logic signed [63:0] S_MAX = 64'sd2147483647;
    localparam logic signed [63:0] S_MIN = -64'sd2147483648;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        WRITE,
        DONE,
        WAIT_START_LOW
    } state_t;

    state_t             state;
    logic [CW-1:0]      f_cnt;
    logic [DW-1:0]      i_cnt;
    logic [DW-1:0]      j_cnt;
    logic [OW-1:0]      o_cnt;
    logic               first_mac;
    logic signed [31:0] feat_d;
    logic signed [63:0] acc;

    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] f_ext;
    logic signed [PW-1:0] prod;
    logic signed [63:0]   prod_ext;
    logic signed [63:0]   acc_sh;
    logic signed [63:0]   bias_ext;
    logic signed [63:0]   s_full;
    logic signed [31:0]   s_sat;
    logic signed [31:0]   feat_cur;
    logic                 last_k;

    always_comb begin
        w_ext    = {{(PW - W_WIDTH){w_data[W_WIDTH-1]}}, w_data};
        f_ext    = {{W_WIDTH{feat_d[31]}}, feat_d};
        prod     = w_ext * f_ext;
        prod_ext = {{(64 - PW){prod[PW-1]}}, prod};
        // Shift kept in its own signed term so the bias add cannot turn it into a logical shift.
        acc_sh   = acc >>> FRAC_BITS;
        bias_ext = {{32{biases[o_cnt][31]}}, biases[o_cnt]};
        s_full   = acc_sh + bias_ext;
        if (s_full > S_MAX)
            s_sat = 32'sh7FFF_FFFF;
        else if (s_full < S_MIN)
            s_sat = 32'sh8000_0000;
        else
            s_sat = s_full[31:0];
        feat_cur = pooled_maps[f_cnt][i_cnt][j_cnt];
        last_k   = (f_cnt == F_LAST) && (i_cnt == D_LAST) && (j_cnt == D_LAST);
    end

`ifdef FC_ARGMAX_EN
    logic signed [31:0] best;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            f_cnt     <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            o_cnt     <= '0;
            first_mac <= 1'b0;
            feat_d    <= '0;
            acc       <= '0;
            done      <= 1'b0;
            w_addr    <= '0;
            scores    <= '{default: '0};
`ifdef FC_ARGMAX_EN
            best      <= '0;
            class_idx <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= MAC;
                        w_addr    <= '0;
                        o_cnt     <= '0;
                        f_cnt     <= '0;
                        i_cnt     <= '0;
                        j_cnt     <= '0;
                        acc       <= '0;
                        first_mac <= 1'b1;
                    end
                end
                MAC: begin
                    // feat_d tracks the element addressed this cycle, aligning with next cycle's w_data.
                    feat_d    <= feat_cur;
                    first_mac <= 1'b0;
                    if (!first_mac)
                        acc <= acc + prod_ext;
                    if (last_k) begin
                        state <= DRAIN;
                        f_cnt <= '0;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end else begin
                        w_addr <= w_addr + W_ADDR_W'(1);
                        if (j_cnt == D_LAST) begin
                            j_cnt <= '0;
                            if (i_cnt == D_LAST) begin
                                i_cnt <= '0;
                                f_cnt <= f_cnt + CW'(1);
                            end else begin
                                i_cnt <= i_cnt + DW'(1);
                            end
                        end else begin
                            j_cnt <= j_cnt + DW'(1);
                        end
                    end
                end
                DRAIN: begin
                    acc   <= acc + prod_ext;
                    state <= WRITE;
                end
                WRITE: begin
                    scores[o_cnt] <= s_sat;
`ifdef FC_ARGMAX_EN
                    if ((o_cnt == '0) || (s_sat > best)) begin
                        best      <= s_sat;
                        class_idx <= o_cnt;
                    end
`endif
                    if (o_cnt == O_LAST) begin
                        state <= DONE;
                    end else begin
                        // Weight rows are contiguous, so the next output's first address is one past the last.
                        o_cnt     <= o_cnt + OW'(1);
                        w_addr    <= w_addr + W_ADDR_W'(1);
                        acc       <= '0;
                        first_mac <= 1'b1;
                        state     <= MAC;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= WAIT_START_LOW;
                end
                WAIT_START_LOW: begin
                    if (!start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef FC_ARGMAX_EN
    assign class_idx = '0;
`endif

endmodule
